// File: rtl/usbh_tx_packetizer.sv
// USB host tx packetizer: PID + len bytes from a FWFT FIFO [+ inverted CRC16 when USBH_TX_CRC16_EN].
// Latency: start_i in cycle N puts the PID on utmi_data_o in N+1, then one byte per accepted cycle.
// Backpressure: txready low holds data/txvalid with no pop or CRC update; an empty FIFO mid-payload aborts.
module usbh_tx_packetizer #(
    parameter int LEN_W = 11
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [7:0]       pid_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [7:0]       fifo_data_i,
    input  logic             fifo_empty_i,
    output logic             fifo_pop_o,
    output logic [7:0]       utmi_data_o,
    output logic             utmi_txvalid_o,
    input  logic             utmi_txready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             underrun_o
);

`ifdef USBH_TX_CRC16_EN
    typedef enum logic [2:0] {S_IDLE, S_PID, S_DATA, S_CRC_LO, S_CRC_HI} state_t;
    localparam state_t TAIL_STATE = S_CRC_LO;
    localparam bit     TAIL_DONE  = 1'b0;
`else
    typedef enum logic [1:0] {S_IDLE, S_PID, S_DATA} state_t;
    localparam state_t TAIL_STATE = S_IDLE;
    localparam bit     TAIL_DONE  = 1'b1;
`endif

    state_t           state_q, state_d;
    logic [7:0]       pid_q;
    logic [LEN_W-1:0] rem_q;
    logic             done_q, done_d;
    logic             underrun_q, underrun_d;

`ifdef USBH_TX_CRC16_EN
    logic [15:0] crc_q;

    // Reflected CRC16 (poly 0xA001), one whole byte per cycle, LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ 16'hA001;
            else             c = c >> 1;
        end
        return c;
    endfunction
`endif

    always_comb begin
        state_d        = state_q;
        utmi_data_o    = 8'h00;
        utmi_txvalid_o = 1'b0;
        fifo_pop_o     = 1'b0;
        done_d         = 1'b0;
        underrun_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_PID;
            end
            S_PID: begin
                utmi_data_o    = pid_q;
                utmi_txvalid_o = 1'b1;
                if (utmi_txready_i) begin
                    if (rem_q != '0) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = TAIL_STATE;
                        done_d  = TAIL_DONE;
                    end
                end
            end
            S_DATA: begin
                utmi_data_o    = fifo_data_i;
                utmi_txvalid_o = ~fifo_empty_i;
                // FIFO ran dry: drop txvalid and abandon the packet without CRC.
                if (fifo_empty_i) begin
                    underrun_d = 1'b1;
                    state_d    = S_IDLE;
                end else if (utmi_txready_i) begin
                    fifo_pop_o = 1'b1;
                    if (rem_q == LEN_W'(1)) begin
                        state_d = TAIL_STATE;
                        done_d  = TAIL_DONE;
                    end
                end
            end
`ifdef USBH_TX_CRC16_EN
            S_CRC_LO: begin
                utmi_data_o    = ~crc_q[7:0];
                utmi_txvalid_o = 1'b1;
                if (utmi_txready_i) state_d = S_CRC_HI;
            end
            S_CRC_HI: begin
                utmi_data_o    = ~crc_q[15:8];
                utmi_txvalid_o = 1'b1;
                if (utmi_txready_i) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            pid_q      <= 8'h00;
            rem_q      <= '0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
            if (state_q == S_IDLE && start_i) begin
                pid_q <= pid_i;
                rem_q <= len_i;
            end else if (fifo_pop_o) begin
                rem_q <= rem_q - LEN_W'(1);
            end
        end
    end

`ifdef USBH_TX_CRC16_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            crc_q <= 16'hFFFF;
        end else if (state_q == S_IDLE && start_i) begin
            crc_q <= 16'hFFFF;
        end else if (fifo_pop_o) begin
            crc_q <= crc16_byte(crc_q, fifo_data_i);
        end
    end
`endif

    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = done_q;
    assign underrun_o = underrun_q;

endmodule

// File: doc/usbh_tx_packetizer.md
# usbh_tx_packetizer

USB host transmit packetizer: drains a prefilled `usbh_fifo` through its pop side and serializes one DATA packet per request onto the UTMI-style transmit byte interface. Each packet is PID, then `len` payload bytes, then an optional CRC16. It sits between the host transaction engine, which supplies PID and length, and the ULPI link wrapper, which consumes `utmi_*`.

## Interface
- `LEN_W`, default 11: width of the payload byte count; maximum payload is 2^LEN_W−1.
- `clk_i` in 1: clock. All logic is on the rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `start_i` in 1: request to send one packet. Sampled only in IDLE.
- `pid_i` in 8: full PID byte, including the complement nibble. Sent verbatim.
- `len_i` in LEN_W: number of payload bytes to pop. 0 means a zero-length packet (ZLP).
- `fifo_data_i` in 8: FIFO head byte. First-word-fall-through: valid whenever `fifo_empty_i` is 0.
- `fifo_empty_i` in 1: FIFO empty flag.
- `fifo_pop_o` out 1: pop strobe, one pulse per consumed byte.
- `utmi_data_o` out 8: transmit byte.
- `utmi_txvalid_o` out 1: transmit byte valid.
- `utmi_txready_i` in 1: link accepted the byte this cycle.
- `busy_o` out 1: packet in progress.
- `done_o` out 1: one-cycle pulse when a packet completes normally.
- `underrun_o` out 1: one-cycle pulse when a packet is aborted because the FIFO ran dry.

## Operation
- States: IDLE, PID, DATA, CRC_LO, CRC_HI.
- **IDLE**
  - `start_i`=1 captures `pid_i` and `len_i` into registers, sets the remaining count to `len_i`, loads CRC to 0xFFFF, and moves to PID.
  - `start_i` is ignored in every other state.
- **PID**
  - `utmi_data_o` is the captured PID and `txvalid` is 1.
  - On `txready`: go to DATA if remaining ≠ 0, otherwise go to CRC_LO.
- **DATA**
  - `utmi_data_o` is `fifo_data_i`, driven combinationally. `txvalid` is the inverse of `fifo_empty_i`.
  - A transfer is the cycle with `txvalid & txready`. On a transfer: `fifo_pop_o`=1 in the same cycle, CRC updates with the byte, and remaining decrements. When remaining reaches 0, go to CRC_LO.
  - If `fifo_empty_i`=1 in DATA, abort: pulse `underrun_o`, go to IDLE, emit no CRC, and do not pulse `done_o`. `txvalid` therefore drops mid-packet and the link signals the abort.
- **CRC_LO / CRC_HI**
  - Send ~crc[7:0], then ~crc[15:8].
  - Hold each byte until `txready`. After CRC_HI is accepted, go to IDLE.
- **CRC16**
  - Reflected polynomial 0xA001 (x^16+x^15+x^2+1), init 0xFFFF.
  - Processed LSB-first, 8 bit-steps per byte in one cycle.
  - Transmitted inverted, low byte first.
- Caller contract: all `len_i` bytes are in the FIFO before `start_i`. Underrun is an error path only.
- `fifo_pop_o` is asserted only on a DATA transfer, so it is never asserted while `fifo_empty_i`=1.
- The remaining counter is LEN_W wide. It never underflows because the 0 check precedes any decrement.

## Timing
- Reset values: `fifo_pop_o`, `utmi_data_o`, `utmi_txvalid_o`, `busy_o`, `done_o`, `underrun_o` all 0.
- Reset is asynchronous. Asserting it mid-packet forces IDLE and drops `txvalid` immediately.
- Start latency: `start_i` high in cycle N gives `txvalid`=1 with the PID in cycle N+1.
- Throughput: with `txready` held high, one byte per cycle. A packet with CRC occupies L+3 consecutive `txvalid` cycles.
- Backpressure: while `txready`=0, `utmi_data_o` and `txvalid` are held stable, with no pop and no CRC update.
- `busy_o` is 1 in every non-IDLE state.
- `done_o` pulses in the cycle after the final accepted byte, which is also the first IDLE cycle.
- A `start_i` in the same cycle as `done_o` is accepted.
- `underrun_o` pulses in the cycle after the empty DATA cycle, which is the first IDLE cycle.

## Configuration
- `USBH_TX_CRC16_EN` defined:
  - CRC_LO and CRC_HI exist, and the CRC is appended as described above.
- `USBH_TX_CRC16_EN` undefined:
  - The CRC register, CRC logic and CRC states are removed.
  - PID with remaining=0, or the last DATA transfer, goes directly to IDLE with `done_o`. Packet length is L+1 bytes.
  - The link layer appends the CRC.

## Test plan
- **ZLP:** `pid_i`=0xC3, `len_i`=0, `txready`=1 → bytes C3, 00, 00 in consecutive cycles. No pops. `done_o` the next cycle.
- **One byte:** FIFO={0x00}, pid 0x4B, len 1 → bytes 4B, 00, 40, BF. Exactly one pop, coincident with byte 00.
- **Backpressure:** FIFO={AA,55}, len 2, `txready` toggling 1/0 → byte sequence unchanged. Each byte stable while not ready. Pops only on accepted AA and 55.
- **Underrun:** FIFO holds 2 bytes, len 4 → after 2 data bytes, `txvalid` drops, `underrun_o` pulses once, no CRC, `done_o` stays 0, `busy_o`=0.
- **Busy and reset:** `start_i` during DATA is ignored. `rst_i` mid-DATA makes all outputs 0 asynchronously. After release, a new ZLP sends C3, 00, 00 correctly.
- **Macro off:** repeat the one-byte case → bytes 4B, 00 only, then `done_o`.
